bcd_decoder: RTL and testbench
==============================

# bcd_decoder

Sequential BCD-to-binary converter: the reverse path of the board's binary-to-BCD/seven-segment display chain. Accepts three BCD digits (hundreds, tens, ones), validates them, and converts them to binary with an iterative reverse double-dabble (shift-right, subtract-3) datapath. Results are returned over a valid/ready handshake with digit-error and range-error flags. It sits between digit-entry logic (switches/keypad) and the binary value bus that feeds the display encoder.

## Interface
- p_digits, 3: number of BCD digits accepted.
- p_bin_w, 10: binary result width; must equal ceil(log2(10^p_digits)).
- p_max, 511: largest in-range result, matching the 9-bit display value bus.
- i_clock_50mhz  in  1  system clock, 50 MHz.
- i_reset  in  1  asynchronous, active-low reset.
- i_bcd  in  4*p_digits  packed BCD, digit 0 in [3:0] (ones).
- i_valid  in  1  input word valid.
- o_ready  out  1  block can accept a word.
- o_bin  out  p_bin_w  converted binary value.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_digit_err  out  1  an input digit was > 9.
- o_range_err  out  1  result > p_max.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: o_ready=1. On i_valid && o_ready, capture i_bcd into the upper field of a {bcd, bin} shift register with bin=0, and clear the counter.
  - If any captured digit > 9: go to DONE with o_bin=0, o_digit_err=1, o_range_err=0. No conversion takes place.
  - Otherwise go to SHIFT.
- SHIFT: each cycle:
  - Shift the whole register right by 1; the BCD LSB enters the bin MSB.
  - Then, in each BCD digit, subtract 3 from any digit >= 8.
  - Counter increments. After p_bin_w shifts, go to DONE.
- DONE: o_valid=1. o_bin, o_digit_err and o_range_err stay stable until i_valid/i_ready... specifically, they are held until the handshake o_valid && i_ready completes, then go to IDLE.
  - o_range_err = (bin > p_max), registered on entry to DONE.
- o_ready=0 in SHIFT and DONE. i_valid is ignored outside IDLE. No input buffering.
- Arithmetic: digit adjust is 4-bit unsigned. The shift register is 4*p_digits + p_bin_w bits wide. o_bin is zero-extended, never truncated.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State=IDLE.
  - o_ready=0 until the first clock edge after release, then 1.
  - o_valid=0, o_bin=0, o_digit_err=0, o_range_err=0.
- Accept on edge E0. Shifts on edges E1..E{p_bin_w}. o_valid is high after edge E{p_bin_w}, so latency is p_bin_w cycles (10 by default).
- Digit-error path: o_valid is high after E1 (1-cycle latency).
- With i_ready held high, o_valid lasts exactly 1 cycle. o_ready returns the cycle after the output handshake.
- Minimum interval between accepts: p_bin_w+2 cycles.
- Backpressure: with i_ready low, DONE holds indefinitely and the outputs do not change.
- Reset mid-SHIFT or mid-DONE: the result is discarded and no o_valid is produced.

## Configuration
- BCD_DECODER_RANGE_CHECK_EN defined: o_range_err is computed as above.
- Not defined: o_range_err is tied to 0 and the comparator is removed. Port list is unchanged.

## Structure
- Package bcd_pkg holds:
  - typedef bcd_digit_t (logic [3:0]);
  - enum bcd_dec_state_t {IDLE, SHIFT, DONE};
  - constant BCD_ADJ = 4'd3;
  - constant BCD_MAX_DIGIT = 4'd9.
- Sub-module bcd_digit_adjust: combinational per-digit "if >= 8, subtract 3". It is instantiated p_digits times via generate.

## Test plan
- 12'h000 -> o_bin=0, no errors, o_valid exactly 10 cycles after accept.
- 12'h255 -> o_bin=255; 12'h511 -> o_bin=511, o_range_err=0.
- 12'h999 -> o_bin=999, o_range_err=1 with macro defined, 0 without.
- 12'h1A3 -> o_digit_err=1, o_bin=0, o_valid 1 cycle after accept.
- 12'h123 with i_ready low for 20 cycles -> o_valid and o_bin=123 held stable; i_valid pulses during SHIFT/DONE are ignored. Next word 12'h045 -> 45.
- i_reset low during SHIFT of 12'h500 -> all outputs go to reset values, no o_valid. After release, o_ready=1 one edge later and 12'h007 -> 7.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD-to-binary decoder.
package bcd_pkg;
   typedef logic [3:0] bcd_digit_t;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_dec_state_t;
   localparam bcd_digit_t BCD_ADJ       = 4'd3;
   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: one reverse double-dabble step for a single digit (subtract 3 when >= 8).
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);
   bcd_digit_t w_digit;
   assign w_digit = i_digit;
   assign o_digit = (w_digit >= 4'd8) ? w_digit - BCD_ADJ : w_digit;
endmodule

// File: rtl/bcd_decoder.sv
// bcd_decoder: multi-digit BCD to binary via iterative reverse double-dabble with valid/ready.
// Define BCD_DECODER_RANGE_CHECK_EN to flag results above p_max on o_range_err.
module bcd_decoder
   import bcd_pkg::*;
#(
   parameter int p_digits = 3,
   parameter int p_bin_w  = 10,
   parameter int p_max    = 511
) (
   input  logic                  i_clock_50mhz,
   input  logic                  i_reset,
   input  logic [4*p_digits-1:0] i_bcd,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [p_bin_w-1:0]    o_bin,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_digit_err,
   output logic                  o_range_err
);
   localparam int c_bcd_w = 4 * p_digits;
   localparam int c_sr_w  = c_bcd_w + p_bin_w;
   localparam int c_cnt_w = $clog2(p_bin_w + 1);
   bcd_dec_state_t     r_state, w_next;
   logic [c_sr_w-1:0]  r_sr, w_shift;
   logic [c_bcd_w-1:0] w_adj;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_armed, r_digit_err;
   logic               w_accept, w_digit_err, w_first_err, w_last;
   assign w_shift = r_sr >> 1;
   for (genvar g = 0; g < p_digits; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .i_digit (w_shift[p_bin_w + 4*g +: 4]),
         .o_digit (w_adj[4*g +: 4])
      );
   end
   // Digits are validated on the captured word, before the first shift moves them.
   always_comb begin
      w_digit_err = 1'b0;
      for (int d = 0; d < p_digits; d++)
         w_digit_err = w_digit_err | (r_sr[p_bin_w + 4*d +: 4] > BCD_MAX_DIGIT);
   end
   assign w_accept    = i_valid && o_ready;
   assign w_first_err = (r_cnt == '0) && w_digit_err;
   assign w_last      = r_cnt == c_cnt_w'(p_bin_w - 1);
   always_ff @(posedge i_clock_50mhz or negedge i_reset)
      if (!i_reset) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? SHIFT : IDLE;
         SHIFT:   w_next = (w_first_err || w_last) ? DONE : SHIFT;
         DONE:    w_next = i_ready ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      o_ready = r_armed && (r_state == IDLE);
      o_valid = r_state == DONE;
   end
   // r_armed keeps o_ready low until the first edge after reset release.
   always_ff @(posedge i_clock_50mhz or negedge i_reset)
      if (!i_reset) begin
         r_armed     <= 1'b0;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_digit_err <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (w_accept) begin
            r_sr        <= {i_bcd, {p_bin_w{1'b0}}};
            r_cnt       <= '0;
            r_digit_err <= 1'b0;
         end else if (r_state == SHIFT) begin
            if (w_first_err) r_digit_err <= 1'b1;
            else begin
               r_sr  <= {w_adj, w_shift[p_bin_w-1:0]};
               r_cnt <= r_cnt + c_cnt_w'(1);
            end
         end
      end
   assign o_bin       = r_sr[p_bin_w-1:0];
   assign o_digit_err = r_digit_err;
`ifdef BCD_DECODER_RANGE_CHECK_EN
   logic r_range_err;
   always_ff @(posedge i_clock_50mhz or negedge i_reset)
      if (!i_reset) r_range_err <= 1'b0;
      else if (w_accept || (r_state == SHIFT && w_first_err)) r_range_err <= 1'b0;
      else if (r_state == SHIFT && w_last) r_range_err <= w_shift[p_bin_w-1:0] > p_bin_w'(p_max);
   assign o_range_err = r_range_err;
`else
   assign o_range_err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_decoder.sv
// tb_bcd_decoder: directed vectors checked against an arithmetic model every cycle plus literal expectations.
module tb_bcd_decoder;
   logic        i_clock_50mhz = 1'b0;
   logic        i_reset;
   logic [11:0] i_bcd = '0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic        o_ready, o_valid, o_digit_err, o_range_err;
   logic [9:0]  o_bin;
   int          n_vec = 0;
   int          n_err = 0;
`ifdef BCD_DECODER_RANGE_CHECK_EN
   localparam bit c_rc = 1'b1;
`else
   localparam bit c_rc = 1'b0;
`endif

   bcd_decoder dut (
      .i_clock_50mhz (i_clock_50mhz),
      .i_reset       (i_reset),
      .i_bcd         (i_bcd),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .o_bin         (o_bin),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_digit_err   (o_digit_err),
      .o_range_err   (o_range_err)
   );

   always #10 i_clock_50mhz = ~i_clock_50mhz;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: result is plain decimal arithmetic; timing is a countdown to the result.
   bit m_armed = 0, m_done = 0, m_derr = 0, m_rerr = 0;
   bit p_derr, p_rerr;
   int m_cnt = 0, m_bin = 0, p_bin;
   always @(posedge i_clock_50mhz or negedge i_reset) begin
      if (!i_reset) begin
         m_armed = 0; m_done = 0; m_cnt = 0; m_bin = 0; m_derr = 0; m_rerr = 0;
      end else begin
         if (m_done) begin
            if (i_ready) m_done = 0;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_done = 1; m_bin = p_bin; m_derr = p_derr; m_rerr = p_rerr;
            end
         end else if (m_armed && i_valid) begin
            int h, t, o;
            h = int'(i_bcd[11:8]); t = int'(i_bcd[7:4]); o = int'(i_bcd[3:0]);
            p_derr = (h > 9) || (t > 9) || (o > 9);
            p_bin  = p_derr ? 0 : 100*h + 10*t + o;
            p_rerr = c_rc && !p_derr && (p_bin > 511);
            m_cnt  = p_derr ? 1 : 10;
         end
         m_armed = 1;
      end
   end

   always @(negedge i_clock_50mhz) begin
      chk("ready", int'(o_ready), int'(m_armed && m_cnt == 0 && !m_done));
      chk("valid", int'(o_valid), int'(m_done));
      if (m_done || !m_armed) begin
         chk("bin", int'(o_bin), m_bin);
         chk("digit_err", int'(o_digit_err), int'(m_derr));
         chk("range_err", int'(o_range_err), int'(m_rerr));
      end
   end

   task automatic send(input logic [11:0] bcd);
      int w = 0;
      while (!o_ready && w < 50) begin @(negedge i_clock_50mhz); w++; end
      chk("ready_wait", int'(o_ready), 1);
      i_bcd = bcd; i_valid = 1'b1;
      @(negedge i_clock_50mhz);
      i_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!o_valid && lat < 50) begin @(negedge i_clock_50mhz); lat++; end
      chk("valid_timeout", int'(o_valid), 1);
   endtask

   task automatic run(input logic [11:0] bcd, input int e_bin, input int e_derr,
                      input int e_rerr, input int e_lat);
      int lat;
      send(bcd);
      wait_valid(lat);
      chk("latency", lat, e_lat);
      chk("lit_bin", int'(o_bin), e_bin);
      chk("lit_digit_err", int'(o_digit_err), e_derr);
      chk("lit_range_err", int'(o_range_err), e_rerr);
      @(negedge i_clock_50mhz);
      chk("valid_one_cycle", int'(o_valid), 0);
      chk("ready_after_hs", int'(o_ready), 1);
   endtask

   initial begin
      int lat;
      #2000000;
      $display("FAIL watchdog at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      i_reset = 1'b1;
      #1 i_reset = 1'b0;
      #2;
      chk("rst_ready", int'(o_ready), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_bin", int'(o_bin), 0);
      repeat (3) @(negedge i_clock_50mhz);
      #5 i_reset = 1'b1;
      #1 chk("ready_before_edge", int'(o_ready), 0);
      @(negedge i_clock_50mhz);
      chk("ready_after_edge", int'(o_ready), 1);
      run(12'h000, 0, 0, 0, 10);
      run(12'h255, 255, 0, 0, 10);
      run(12'h511, 511, 0, 0, 10);
      run(12'h999, 999, 0, int'(c_rc), 10);
      run(12'h1A3, 0, 1, 0, 1);
      i_ready = 1'b0;
      send(12'h123);
      for (int k = 0; k < 9; k++) begin
         i_valid = k[0]; i_bcd = 12'h999;
         @(negedge i_clock_50mhz);
      end
      i_valid = 1'b0;
      wait_valid(lat);
      chk("bp_latency", lat + 9, 10);
      for (int k = 0; k < 20; k++) begin
         chk("bp_valid", int'(o_valid), 1);
         chk("bp_bin", int'(o_bin), 123);
         i_valid = ~k[0]; i_bcd = 12'h888;
         @(negedge i_clock_50mhz);
      end
      i_valid = 1'b0;
      chk("bp_still_valid", int'(o_valid), 1);
      i_ready = 1'b1;
      @(negedge i_clock_50mhz);
      chk("bp_released", int'(o_valid), 0);
      run(12'h045, 45, 0, 0, 10);
      send(12'h500);
      repeat (4) @(negedge i_clock_50mhz);
      #5 i_reset = 1'b0;
      #1;
      chk("mid_rst_valid", int'(o_valid), 0);
      chk("mid_rst_ready", int'(o_ready), 0);
      chk("mid_rst_bin", int'(o_bin), 0);
      repeat (2) @(negedge i_clock_50mhz);
      #5 i_reset = 1'b1;
      #1 chk("rel_ready_before", int'(o_ready), 0);
      @(negedge i_clock_50mhz);
      chk("rel_ready_after", int'(o_ready), 1);
      repeat (12) begin
         chk("no_stale_valid", int'(o_valid), 0);
         @(negedge i_clock_50mhz);
      end
      run(12'h007, 7, 0, 0, 10);
      repeat (2) @(negedge i_clock_50mhz);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
